plab4_net_router_output_arb: RTL
================================

PLAB4_NET_ROUTER_OUTPUT_ARB -- requirements
Module: plab4_net_router_output_arb

Interface
REQ-001 Parameter p_num_credits, default 2: downstream buffer entries per output channel (range 1..7).
REQ-002 Parameter p_num_free_nbits, default 2: width of num_free; SHALL satisfy 2^p_num_free_nbits > p_num_credits.
REQ-003 Parameter p_epoch_len, default 8: cycles per TDM epoch (range 2..255); used only under the configuration macro.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-006 domain_ID  input  1  security domain of the traffic presented this cycle.
REQ-007 reqs  input  3  requests from input controls: bit0 east-in, bit1 terminal-in, bit2 west-in.
REQ-008 grants  output  3  one-hot or zero grant vector, same bit order as reqs.
REQ-009 out_val  output  1  flit is driven onto the output channel this cycle.
REQ-010 out_rdy  input  1  downstream link accepts a flit this cycle.
REQ-011 credit_ret  input  1  one-cycle pulse: one downstream entry freed.
REQ-012 num_free  output  p_num_free_nbits  current credit count, exported to neighbouring input controls.
REQ-013 tdm_domain  output  1  domain currently owning the output channel.
REQ-014 credit_err  output  1  sticky: credit_ret arrived while count was p_num_credits.

Function
REQ-015 Arbitration: combinational; grants SHALL select the first asserted reqs bit found scanning upward from prio_ptr, wrapping 2→0.
REQ-016 Gating: grants SHALL be 3'b000 when num_free==0, reset is asserted, or (under the macro) the TDM gate is closed.
REQ-017 out_val SHALL equal |grants; a transfer occurs when out_val && out_rdy.
REQ-018 prio_ptr (2 bits, values 0..2) SHALL advance to (granted index+1) mod 3 on a transfer and SHALL hold otherwise, including a grant with out_rdy=0.
REQ-019 Credits: a transfer alone SHALL decrement num_free by 1; credit_ret alone SHALL increment it by 1; both together SHALL leave it unchanged.
REQ-020 A credit_ret at num_free==p_num_credits without a simultaneous transfer SHALL leave num_free saturated and set credit_err.
REQ-021 A transfer at num_free==1 SHALL bring num_free to 0 and block grants from the next cycle until a credit_ret arrives.
REQ-022 Latency: request-to-grant is 0 cycles; credit_ret affects num_free and gating in the following cycle.
REQ-023 Without the macro, tdm_domain SHALL be constant 0.

Reset
REQ-024 While reset==0 at a clock edge: prio_ptr=0, num_free=p_num_credits, credit_err=0, epoch counter=0, tdm_domain=0.
REQ-025 During any reset cycle, grants and out_val SHALL be 0. Reset mid-transfer SHALL discard the transfer's credit update. Credits still outstanding downstream are re-initialized to full.

Configuration
REQ-026 Macro PLAB4_NET_ROUTER_OUTPUT_ARB_TDM_EN. When defined, compile in TDM timing-channel protection per REQ-027..029.
REQ-027 When defined: an epoch counter SHALL count 0..p_epoch_len-1 and wrap. tdm_domain SHALL toggle on each wrap.
REQ-028 When defined: the gate SHALL be open only when domain_ID==tdm_domain and the epoch counter != p_epoch_len-1. The last cycle of each epoch is a dead cycle.
REQ-029 When not defined: the gate SHALL always be open, and no epoch counter SHALL be instantiated.

Verification
REQ-030 Bench SHALL cover the following directed scenarios:
- Round-robin: reqs=3'b111, out_rdy=1, with credit_ret pulsed each cycle → grants sequence 001, 010, 100, 001; num_free holds at 2.
- Stall hold: reqs=3'b110, out_rdy=0 for 3 cycles → grants=010 every cycle; prio_ptr and num_free unchanged.
- Credit exhaustion: p_num_credits=2, reqs=001, out_rdy=1, no credit_ret → 2 transfers, then num_free=0 and grants=000. One credit_ret → num_free=1 the next cycle and one more grant.
- Overflow: credit_ret at num_free=2 with no traffic → num_free stays 2, credit_err=1 until reset.
- TDM (macro on, p_epoch_len=4): domain_ID=1, reqs=010 from reset → no grant in cycles 0-3; grants in cycles 4-6; none in cycle 7 (dead cycle).
- Mid-operation reset: transfer in progress, reset=0 for one cycle → grants=000 that cycle; afterwards num_free=2, prio_ptr=0.

Source files
------------

// File: rtl/plab4_net_router_output_arb_if.sv
// Output-port bundle between the router's input controls / downstream link and the output arbiter.
// master drives requests and link status; slave (the arbiter) returns grants and credit state.
interface plab4_net_router_output_arb_if #(
  parameter int p_num_free_nbits = 2
);
  logic                        domain_ID;
  logic [2:0]                  reqs;
  logic [2:0]                  grants;
  logic                        out_val;
  logic                        out_rdy;
  logic                        credit_ret;
  logic [p_num_free_nbits-1:0] num_free;
  logic                        tdm_domain;
  logic                        credit_err;

  modport master (
    output domain_ID, reqs, out_rdy, credit_ret,
    input  grants, out_val, num_free, tdm_domain, credit_err
  );

  modport slave (
    input  domain_ID, reqs, out_rdy, credit_ret,
    output grants, out_val, num_free, tdm_domain, credit_err
  );
endinterface

// File: rtl/plab4_net_router_output_arb.sv
// Credit-gated round-robin output arbiter: 0-cycle request-to-grant, credit_ret visible next cycle,
// holds grant and priority while out_rdy=0. TDM epoch gating under PLAB4_NET_ROUTER_OUTPUT_ARB_TDM_EN.
module plab4_net_router_output_arb #(
  parameter int p_num_credits    = 2,
  parameter int p_num_free_nbits = 2,
  parameter int p_epoch_len      = 8
) (
  input logic                          clk,
  input logic                          reset,
  plab4_net_router_output_arb_if.slave arb_if
);

  localparam logic [p_num_free_nbits-1:0] CREDITS_FULL = p_num_free_nbits'(p_num_credits);
  localparam logic [p_num_free_nbits-1:0] CREDIT_ONE   = p_num_free_nbits'(1);
  localparam logic [7:0]                  EPOCH_LAST   = 8'(p_epoch_len - 1);

  logic [1:0]                  prio_q, prio_d;
  logic [p_num_free_nbits-1:0] num_free_q, num_free_d;
  logic                        credit_err_q, credit_err_d;

  logic                        gate_open;
  logic                        tdm_domain_w;
  logic [1:0]                  scan;
  logic [1:0]                  win_idx;
  logic                        win_any;
  logic                        grant_en;
  logic [2:0]                  grants_w;
  logic                        xfer;

`ifdef PLAB4_NET_ROUTER_OUTPUT_ARB_TDM_EN
  logic [7:0] epoch_q, epoch_d;
  logic       tdm_domain_q, tdm_domain_d;

  // The final cycle of each epoch is dead so no flit can straddle a domain switch.
  assign gate_open    = (arb_if.domain_ID == tdm_domain_q) && (epoch_q != EPOCH_LAST);
  assign tdm_domain_w = tdm_domain_q;

  always_comb begin
    epoch_d      = epoch_q + 8'd1;
    tdm_domain_d = tdm_domain_q;
    if (epoch_q == EPOCH_LAST) begin
      epoch_d      = 8'd0;
      tdm_domain_d = ~tdm_domain_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      epoch_q      <= 8'd0;
      tdm_domain_q <= 1'b0;
    end else begin
      epoch_q      <= epoch_d;
      tdm_domain_q <= tdm_domain_d;
    end
  end
`else
  logic unused_cfg;

  assign gate_open    = 1'b1;
  assign tdm_domain_w = 1'b0;
  assign unused_cfg   = ^{arb_if.domain_ID, EPOCH_LAST};
`endif

  // Rotating scan starting at prio_q; the first asserted request wins.
  always_comb begin
    scan    = prio_q;
    win_idx = 2'd0;
    win_any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!win_any && arb_if.reqs[scan]) begin
        win_any = 1'b1;
        win_idx = scan;
      end
      scan = (scan == 2'd2) ? 2'd0 : scan + 2'd1;
    end
  end

  assign grant_en = reset && (num_free_q != '0) && gate_open;
  assign grants_w = (win_any && grant_en) ? (3'b001 << win_idx) : 3'b000;
  assign xfer     = (|grants_w) && arb_if.out_rdy;

  always_comb begin
    prio_d       = prio_q;
    num_free_d   = num_free_q;
    credit_err_d = credit_err_q;
    if (xfer) begin
      prio_d = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
    end
    if (xfer && !arb_if.credit_ret) begin
      num_free_d = num_free_q - CREDIT_ONE;
    end else if (!xfer && arb_if.credit_ret) begin
      if (num_free_q == CREDITS_FULL) begin
        credit_err_d = 1'b1;
      end else begin
        num_free_d = num_free_q + CREDIT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_q       <= 2'd0;
      num_free_q   <= CREDITS_FULL;
      credit_err_q <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      num_free_q   <= num_free_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign arb_if.grants     = grants_w;
  assign arb_if.out_val    = |grants_w;
  assign arb_if.num_free   = num_free_q;
  assign arb_if.tdm_domain = tdm_domain_w;
  assign arb_if.credit_err = credit_err_q;

endmodule
